// File: rtl/pipe_trace_pkg.sv
// Shared types and constants for the pipeline trace monitor.
package pipe_trace_pkg;

  // Trace entry type codes, as seen on trace_type.
  localparam logic [1:0] TR_WB  = 2'b00;
  localparam logic [1:0] TR_ST  = 2'b01;
  localparam logic [1:0] TR_RES = 2'b10;

  // Monitor state: capture events, dump result window, finished.
  typedef enum logic [1:0] {
    RUN  = 2'b00,
    DUMP = 2'b01,
    DONE = 2'b10
  } state_t;

  // Packed entry layout is {type, pc, idx, data}; this gives its total width.
  function automatic int entry_width(input int data_w, input int idx_w);
    return 2 + data_w + idx_w + data_w;
  endfunction

endpackage

// File: rtl/trace_fifo_2w.sv
// Circular FIFO with two write ports (same cycle, consecutive slots) and one
// first-word-fall-through read port. The caller guarantees capacity; a pop on
// an empty FIFO is ignored.
module trace_fifo_2w #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  logic [W-1:0]             din0,
  input  logic                     push1,
  input  logic [W-1:0]             din1,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;
  logic [AW-1:0] wptr1_s;

  // Second write lands after the first one when both are used.
  assign pop_s   = pop & (count_r != {CW{1'b0}});
  assign wptr1_s = wptr_r + AW'(push0);

  assign dout  = mem_r[rptr_r];
  assign count = count_r;
  assign valid = (count_r != {CW{1'b0}});

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push0) begin
        mem_r[wptr_r] <= din0;
      end
      if (push1) begin
        mem_r[wptr1_s] <= din1;
      end
      wptr_r  <= wptr_r + AW'(push0) + AW'(push1);
      rptr_r  <= rptr_r + AW'(pop_s);
      count_r <= count_r + CW'(push0) + CW'(push1) - CW'(pop_s);
    end
  end

endmodule

// File: rtl/pipe_trace_monitor.sv
// Pipeline trace monitor: captures writeback/store events into a trace FIFO
// until the halt PC is fetched, then streams a window of result words from
// data memory into the same FIFO and parks in DONE.
module pipe_trace_monitor
  import pipe_trace_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 REG_W    = 5,
  parameter int                 IDX_W    = 10,
  parameter int                 DEPTH    = 16,
  parameter logic [DATA_W-1:0]  HALT_PC  = 32'h000000D0,
  parameter logic [IDX_W-1:0]   RES_BASE = 10'h100,
  parameter int                 RES_CNT  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              st_en,
  input  logic [DATA_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_rd_en,
  output logic [IDX_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              trace_valid,
  output logic [1:0]        trace_type,
  output logic [DATA_W-1:0] trace_pc,
  output logic [IDX_W-1:0]  trace_idx,
  output logic [DATA_W-1:0] trace_data,
  input  logic              trace_pop,
  output logic [15:0]       drop_cnt,
  output logic              halted
);

  localparam int EW = entry_width(DATA_W, IDX_W);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(RES_CNT + 1);

  state_t          state_r;
  logic [RW-1:0]   rd_cnt_r;
  logic [RW-1:0]   ret_cnt_r;
  logic            ret_pend_r;
  logic [IDX_W-1:0] ret_addr_r;

  logic            push0_s;
  logic            push1_s;
  logic [EW-1:0]   din0_s;
  logic [EW-1:0]   din1_s;
  logic [EW-1:0]   head_s;
  logic [CW-1:0]   count_s;
  logic            pop_ok_s;
  logic [CW-1:0]   free_s;
  logic [1:0]      drop_inc_s;
  logic [CW:0]     count_next_s;
  logic            issue_s;
  logic [16:0]     drop_sum_s;

  logic [EW-1:0]   wb_entry_s;
  logic [EW-1:0]   st_entry_s;
  logic [EW-1:0]   res_entry_s;

  // Store index is the word address of the byte address, truncated.
  assign wb_entry_s  = {TR_WB,  pc,      IDX_W'(wb_reg),       wb_data};
  assign st_entry_s  = {TR_ST,  pc,      st_addr[IDX_W+1:2],   st_data};
  assign res_entry_s = {TR_RES, HALT_PC, ret_addr_r,           mem_rd_data};

  assign pop_ok_s = trace_pop & trace_valid;
  // A same-cycle pop frees a slot for this cycle's pushes.
  assign free_s   = CW'(DEPTH) - count_s + CW'(pop_ok_s);

  trace_fifo_2w #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0_s),
    .din0  (din0_s),
    .push1 (push1_s),
    .din1  (din1_s),
    .pop   (pop_ok_s),
    .dout  (head_s),
    .count (count_s),
    .valid (trace_valid)
  );

  assign {trace_type, trace_pc, trace_idx, trace_data} = head_s;

  // Push steering and drop accounting: WB takes the first free slot, ST the next.
  always_comb begin
    push0_s    = 1'b0;
    push1_s    = 1'b0;
    din0_s     = wb_entry_s;
    din1_s     = st_entry_s;
    drop_inc_s = 2'd0;
    case (state_r)
      RUN: begin
        if (wb_en && st_en) begin
          if (free_s >= CW'(2)) begin
            push0_s = 1'b1;
            push1_s = 1'b1;
          end else if (free_s == CW'(1)) begin
            push0_s    = 1'b1;
            drop_inc_s = 2'd1;
          end else begin
            drop_inc_s = 2'd2;
          end
        end else if (wb_en) begin
          if (free_s != {CW{1'b0}}) begin
            push0_s = 1'b1;
          end else begin
            drop_inc_s = 2'd1;
          end
        end else if (st_en) begin
          din0_s = st_entry_s;
          if (free_s != {CW{1'b0}}) begin
            push0_s = 1'b1;
          end else begin
            drop_inc_s = 2'd1;
          end
        end else begin
          push0_s = 1'b0;
        end
      end
      DUMP: begin
        din0_s  = res_entry_s;
        push0_s = ret_pend_r;
      end
      default: begin
        push0_s = 1'b0;
      end
    endcase
  end

  // Read issue: the occupancy after this edge plus the read already in flight
  // must leave room for the new read's return, so RES entries never drop.
  always_comb begin
    count_next_s = {1'b0, count_s} + (CW+1)'(push0_s) + (CW+1)'(push1_s)
                   - (CW+1)'(pop_ok_s);
    if (state_r == DUMP && rd_cnt_r < RW'(RES_CNT)) begin
      issue_s = (count_next_s + (CW+1)'(mem_rd_en)) < (CW+1)'(DEPTH);
    end else begin
      issue_s = 1'b0;
    end
  end

  assign drop_sum_s = {1'b0, drop_cnt} + 17'(drop_inc_s);

  // Saturating count of events lost to a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 16'h0000;
    end else if (drop_sum_s > 17'h0FFFF) begin
      drop_cnt <= 16'hFFFF;
    end else begin
      drop_cnt <= drop_sum_s[15:0];
    end
  end

  // Monitor FSM with the result-window read sequencer and return tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= {IDX_W{1'b0}};
      rd_cnt_r    <= {RW{1'b0}};
      ret_cnt_r   <= {RW{1'b0}};
      ret_pend_r  <= 1'b0;
      ret_addr_r  <= {IDX_W{1'b0}};
      halted      <= 1'b0;
    end else begin
      ret_pend_r <= mem_rd_en;
      ret_addr_r <= mem_rd_addr;
      case (state_r)
        RUN: begin
          mem_rd_en <= 1'b0;
          if (pc == HALT_PC) begin
            state_r <= DUMP;
          end else begin
            state_r <= RUN;
          end
        end
        DUMP: begin
          if (issue_s) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= RES_BASE + IDX_W'(rd_cnt_r);
            rd_cnt_r    <= rd_cnt_r + RW'(1);
          end else begin
            mem_rd_en <= 1'b0;
          end
          if (ret_pend_r) begin
            ret_cnt_r <= ret_cnt_r + RW'(1);
            if (ret_cnt_r == RW'(RES_CNT - 1)) begin
              state_r <= DONE;
              halted  <= 1'b1;
            end else begin
              state_r <= DUMP;
            end
          end else begin
            state_r <= DUMP;
          end
        end
        DONE: begin
          mem_rd_en <= 1'b0;
          halted    <= 1'b1;
        end
        default: begin
          state_r   <= RUN;
          mem_rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Self-checking bench for pipe_trace_monitor with a queue-based reference model.
module tb_pipe_trace_monitor;

  localparam int          DEPTH    = 4;
  localparam int          RES_CNT  = 5;
  localparam logic [31:0] HALT_PC  = 32'h000000D0;
  localparam logic [9:0]  RES_BASE = 10'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_reg = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        st_en = 1'b0;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = 32'h0;
  logic        trace_valid;
  logic [1:0]  trace_type;
  logic [31:0] trace_pc;
  logic [9:0]  trace_idx;
  logic [31:0] trace_data;
  logic        trace_pop = 1'b0;
  logic [15:0] drop_cnt;
  logic        halted;

  always #5 clk = ~clk;

  pipe_trace_monitor #(
    .DATA_W(32), .REG_W(5), .IDX_W(10), .DEPTH(DEPTH),
    .HALT_PC(HALT_PC), .RES_BASE(RES_BASE), .RES_CNT(RES_CNT)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .trace_valid(trace_valid), .trace_type(trace_type), .trace_pc(trace_pc),
    .trace_idx(trace_idx), .trace_data(trace_data), .trace_pop(trace_pop),
    .drop_cnt(drop_cnt), .halted(halted)
  );

  // Data memory with one-cycle read latency; log of every issued read address.
  logic [31:0] dmem [0:1023];
  logic [9:0]  rd_log [$];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= dmem[mem_rd_addr];
    if (!rst && mem_rd_en) rd_log.push_back(mem_rd_addr);
  end

  typedef struct {
    logic [1:0]  t;
    logic [31:0] p;
    logic [9:0]  idx;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];      // expected FIFO contents from capture
  ent_t res_q[$];  // expected result entries still to be delivered
  int   m_drop;
  bit   m_dump;
  int   checks = 0;
  int   failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input ent_t e);
    check_val("head_type", 64'(trace_type), 64'(e.t));
    check_val("head_pc",   64'(trace_pc),   64'(e.p));
    check_val("head_idx",  64'(trace_idx),  64'(e.idx));
    check_val("head_data", 64'(trace_data), 64'(e.d));
  endtask

  // Called at a negedge: check the head, apply one cycle of inputs, update model.
  task automatic step(input bit w, input logic [4:0] wr, input logic [31:0] wd,
                      input bit s, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [31:0] p, input bit pp);
    bit eff_pop;
    int free;
    if (q.size() > 0) begin
      check_val("valid", 64'(trace_valid), 64'd1);
      check_head(q[0]);
    end else if (!m_dump || res_q.size() == 0) begin
      check_val("valid_empty", 64'(trace_valid), 64'd0);
    end else if (trace_valid) begin
      check_head(res_q[0]);
    end
    eff_pop = pp && (q.size() > 0 || (m_dump && trace_valid));
    wb_en = w; wb_reg = wr; wb_data = wd;
    st_en = s; st_addr = sa; st_data = sd;
    pc = p; trace_pop = pp;
    @(posedge clk);
    if (eff_pop) begin
      if (q.size() > 0) void'(q.pop_front());
      else if (res_q.size() > 0) void'(res_q.pop_front());
    end
    if (!m_dump) begin
      free = DEPTH - q.size();
      if (w) begin
        if (free > 0) begin q.push_back('{2'd0, p, {5'd0, wr}, wd}); free--; end
        else m_drop++;
      end
      if (s) begin
        if (free > 0) begin q.push_back('{2'd1, p, sa[11:2], sd}); free--; end
        else m_drop++;
      end
      if (p == HALT_PC) begin
        m_dump = 1'b1;
        for (int k = 0; k < RES_CNT; k++)
          res_q.push_back('{2'd2, HALT_PC, RES_BASE + 10'(k), dmem[RES_BASE + 10'(k)]});
      end
    end
    if (m_drop > 65535) m_drop = 65535;
    @(negedge clk);
    check_val("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic idle(input bit pp);
    step(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0000_0004, pp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_en = 1'b0; st_en = 1'b0; trace_pop = 1'b0; pc = 32'h0;
    q.delete(); res_q.delete(); m_drop = 0; m_dump = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_valid",  64'(trace_valid), 64'd0);
    check_val("rst_type",   64'(trace_type),  64'd0);
    check_val("rst_pc",     64'(trace_pc),    64'd0);
    check_val("rst_idx",    64'(trace_idx),   64'd0);
    check_val("rst_data",   64'(trace_data),  64'd0);
    check_val("rst_rd_en",  64'(mem_rd_en),   64'd0);
    check_val("rst_rd_addr",64'(mem_rd_addr), 64'd0);
    check_val("rst_drop",   64'(drop_cnt),    64'd0);
    check_val("rst_halted", 64'(halted),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_log.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && (q.size() > 0 || res_q.size() > 0); i++) idle(1'b1);
    check_val(tag, 64'(q.size() + res_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] rp;
    for (int i = 0; i < 1024; i++) dmem[i] = $urandom;
    dmem[10'h100] = 32'h11; dmem[10'h101] = 32'h22; dmem[10'h102] = 32'h33;
    dmem[10'h103] = 32'h44; dmem[10'h104] = 32'h55;

    do_reset();
    // Single WB, then a store (popping the WB), then pop the store.
    step(1'b1, 5'd8, 32'h0000_002A, 1'b0, 32'h0, 32'h0, 32'h10, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 32'h14, 1'b1);
    idle(1'b1);
    // Both on an empty FIFO, then both with one free slot.
    step(1'b1, 5'd3, 32'h333, 1'b1, 32'h0000_0010, 32'h444, 32'h18, 1'b0);
    step(1'b1, 5'd4, 32'h555, 1'b0, 32'h0, 32'h0, 32'h1C, 1'b0);
    step(1'b1, 5'd6, 32'h666, 1'b1, 32'h0000_0020, 32'h777, 32'h20, 1'b0);
    drain("drain_dual");
    // DEPTH+3 single events with no pops.
    for (int i = 0; i < DEPTH + 3; i++)
      step(1'b1, 5'(i + 1), 32'(100 + i), 1'b0, 32'h0, 32'h0, 32'(32'h40 + 4 * i), 1'b0);
    drain("drain_overflow");

    // Randomized capture traffic.
    for (int i = 0; i < 300; i++) begin
      rp = $urandom;
      if (rp == HALT_PC) rp = rp + 32'd4;
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
           1'($urandom_range(0, 1)), $urandom, $urandom, rp,
           1'($urandom_range(0, 2) != 0));
    end
    drain("drain_random");
    check_val("halted_run", 64'(halted), 64'd0);

    // Halt with an empty FIFO and continuous pops.
    step(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, HALT_PC, 1'b1);
    drain("drain_dump");
    check_val("halted_done", 64'(halted), 64'd1);
    check_val("rd_count", 64'(rd_log.size()), 64'(RES_CNT));
    for (int k = 0; k < rd_log.size() && k < RES_CNT; k++)
      check_val("rd_addr", 64'(rd_log[k]), 64'(RES_BASE + 10'(k)));
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd9, 32'h99, 1'b1, 32'h8, 32'h88, 32'h30, 1'b1);

    // Halt with three entries queued and pops held off for ten cycles.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'(i + 10), 32'(200 + i), 1'b0, 32'h0, 32'h0, 32'(32'h80 + 4 * i), 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, HALT_PC, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b0);
    check_val("stall_reads", 64'(rd_log.size()), 64'(DEPTH - 3));
    drain("drain_stall");
    check_val("halted_stall", 64'(halted), 64'd1);
    check_val("rd_count_stall", 64'(rd_log.size()), 64'(RES_CNT));

    // Reset in the middle of a dump, then confirm capture works again.
    do_reset();
    step(1'b1, 5'd1, 32'h11, 1'b0, 32'h0, 32'h0, 32'h20, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, HALT_PC, 1'b0);
    idle(1'b0);
    idle(1'b0);
    do_reset();
    step(1'b1, 5'd3, 32'h77, 1'b0, 32'h0, 32'h0, 32'h24, 1'b0);
    idle(1'b1);
    idle(1'b0);
    check_val("halted_after_rst", 64'(halted), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
